uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- Receive-side serial front end of the UART.
- Oversamples the asynchronous rx line, detects and validates start bits, and shifts in 5–8 data bits with optional parity and 1 or 2 stop bits.
- Pushes each completed character into the RX queue through a single-cycle write strobe.
- Sits between the pad and the RX FIFO. Takes its sample tick from the UART main clock divider and its frame format from config register B.

Parameters:
OVERSAMPLE, 16, sample_tick pulses per bit period; power of two, at least 8.
SYNC_STAGES, 2, flip-flop stages in the rx input synchronizer.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud (main clock divider output)
enable  input  1  receiver enable
rx  input  1  asynchronous serial line; idles high
data_bits_count  input  2  data bits minus 5 (00=5 … 11=8)
parity_type  input  2  00 none, 01 odd, 10 even, 11 none
double_stop_bits  input  1  1 = two stop bits
fifo_full  input  1  RX queue full
dout  output  8  received character, right-aligned, unused upper bits 0
dout_we  output  1  one-clk write strobe to RX queue
frame_error  output  1  one-clk pulse: a stop bit was sampled low
parity_error  output  1  one-clk pulse: parity mismatch
overrun  output  1  one-clk pulse: character dropped because the queue was full
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchronizer flops are forced to 1 and state goes to IDLE.
  - All counters, the shift register and every output clear to 0 (dout=0, dout_we=0, all error pulses 0, busy=0).
  - The armed flag clears.
- Synchronizer: rx passes through SYNC_STAGES flops; all logic uses the synchronized value rx_s.
- Tick counter:
  - log2(OVERSAMPLE) bits, advances only on sample_tick.
  - Cleared on every state entry.
  - Mid-bit point: count == OVERSAMPLE/2-1. Full bit: count == OVERSAMPLE-1.
- Armed flag: set when rx_s==1 in IDLE. A start bit can only be detected while armed, which prevents a held-low line (break) from retriggering.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - When enable && armed && rx_s==0: go to START.
  - On entry to START, latch data_bits_count, parity_type and double_stop_bits into frame-config registers. Config changes mid-frame have no effect.
- START: at the mid-bit tick:
  - rx_s==1 → false start, return to IDLE with no output.
  - rx_s==0 → go to DATA and clear the counter. From here on every sample point lies mid-bit.
- DATA:
  - At each full-bit tick, shift rx_s in LSB-first and increment the bit index.
  - After the latched N = data_bits_count+5 bits: go to PARITY if parity is enabled, else STOP1.
- PARITY:
  - At the full-bit tick, sample the parity bit.
  - Expected parity: XOR of the N data bits, inverted for odd parity.
  - Mismatch is held internally until the end of the frame.
- STOP1: at the full-bit tick, sample rx_s; a 0 marks a frame error. Go to STOP2 if double stop bits, else end the frame.
- STOP2: same sampling as STOP1, then end the frame.
- Frame end: registered outputs are updated on the clk after the final stop sample, then state returns to IDLE (armed flag cleared).
  - fifo_full=0: dout_we=1 for one clk and dout holds the character. frame_error and parity_error pulse in the same clk if flagged. Characters with errors are still written.
  - fifo_full=1: no write and overrun=1 for one clk. The error flags still pulse.
- dout holds its last value until the next write.
- enable deasserted mid-frame: abort to IDLE on the next clk with no strobes.
- A sample_tick that coincides with a state transition is consumed by the transition; it is not counted twice.
- Simultaneous dout_we and a queue read are the FIFO's concern; this block only looks at fifo_full.

Decomposition:
- uart_pkg:
  - parity_t enum (NONE, ODD, EVEN).
  - rx_state_t enum.
  - DATA_BITS_BASE = 5.
  - Frame-config struct {parity_type, data_bits_count, double_stop_bits}, matching the config-register-B field order.
- One sub-module: sync_ff (parameterized depth, async active-low reset to a parameter value). It is reused later for the CTS input.

Test Plan:
- 8N1, OVERSAMPLE=16, sample_tick every 4 clk, send 0xA5 → one dout_we pulse, dout=0xA5, no error pulses, busy low afterwards.
- 7E1, send 0x35 with correct parity bit 0 → dout=0x35. Repeat with parity bit flipped → dout=0x35 and parity_error pulses coincident with dout_we.
- 5O2, send 0x1F with the second stop bit forced low → dout=0x1F, frame_error=1. Then hold rx low for 40 bit times → no further dout_we until rx returns high and a new start bit arrives.
- Glitch: rx low for 5 ticks, then high → state returns to IDLE, no dout_we, busy drops within one bit time.
- fifo_full=1 during the frame end of 0x42 → dout_we=0, overrun pulse. Deassert fifo_full and send 0x43 → dout=0x43 written.
- Async reset asserted mid-DATA → outputs 0 immediately, without waiting for clk. After release, send 0x80 → received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// UART receive-side shared types.
// Frame-config struct mirrors config register B field order.
package uart_pkg;

  localparam int DATA_BITS_BASE = 5;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_t;

  typedef struct packed {
    parity_t    parity_type;
    logic [1:0] data_bits_count;
    logic       double_stop_bits;
  } frame_cfg_t;

  // Encoding 11 also means no parity.
  function automatic parity_t to_parity(input logic [1:0] p);
    unique case (p)
      2'b01:   return PAR_ODD;
      2'b10:   return PAR_EVEN;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for asynchronous inputs.
// Resets every stage to RST_VAL.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= {DEPTH{RST_VAL}};
    else        ff <= (ff << 1) | DEPTH'(d);
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled start detect, 5-8 data bits,
// optional parity, 1 or 2 stop bits, one write per character.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       enable,
  input  logic       rx,
  input  logic [1:0] data_bits_count,
  input  logic [1:0] parity_type,
  input  logic       double_stop_bits,
  input  logic       fifo_full,
  output logic [7:0] dout,
  output logic       dout_we,
  output logic       frame_error,
  output logic       parity_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);

  logic       rx_s;
  rx_state_t  state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  frame_cfg_t cfg, cfg_n;
  logic       armed, armed_n;
  logic       perr, perr_n;
  logic       ferr, ferr_n;
  logic [7:0] dout_n;
  logic       we_n, fe_n, pe_n, ov_n;
  logic       mid, full, fin, exp_par;

  sync_ff #(
    .DEPTH  (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  assign mid     = sample_tick && (cnt == CW'(OVERSAMPLE/2 - 1));
  assign full    = sample_tick && (cnt == CW'(OVERSAMPLE - 1));
  assign exp_par = (^sh) ^ (cfg.parity_type == PAR_ODD);
  assign busy    = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    cfg_n   = cfg;
    armed_n = armed;
    perr_n  = perr;
    ferr_n  = ferr;
    dout_n  = dout;
    we_n    = 1'b0;
    fe_n    = 1'b0;
    pe_n    = 1'b0;
    ov_n    = 1'b0;
    fin     = 1'b0;
    if (sample_tick) cnt_n = cnt + 1'b1;
    if (state == IDLE && rx_s) armed_n = 1'b1;
    if (!enable && state != IDLE) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (enable && armed && !rx_s) begin
          state_n = START;
          armed_n = 1'b0;
          idx_n   = '0;
          sh_n    = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
          cfg_n   = '{to_parity(parity_type),
                      data_bits_count, double_stop_bits};
        end
        START: if (mid) state_n = rx_s ? IDLE : DATA;
        DATA: if (full) begin
          sh_n  = {rx_s, sh[7:1]};
          idx_n = idx + 1'b1;
          if (idx == {1'b0, cfg.data_bits_count} + 3'd4)
            state_n = (cfg.parity_type != PAR_NONE) ? PARITY : STOP1;
        end
        PARITY: if (full) begin
          perr_n  = (rx_s != exp_par);
          state_n = STOP1;
        end
        STOP1: if (full) begin
          ferr_n = ferr | ~rx_s;
          if (cfg.double_stop_bits) state_n = STOP2;
          else                      fin     = 1'b1;
        end
        STOP2: if (full) begin
          ferr_n = ferr | ~rx_s;
          fin    = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
    if (fin) begin
      state_n = IDLE;
      armed_n = 1'b0;
      fe_n    = ferr_n;
      pe_n    = perr;
      if (fifo_full) begin
        ov_n = 1'b1;
      end else begin
        we_n   = 1'b1;
        dout_n = sh >> (2'd3 - cfg.data_bits_count);
      end
    end
    // A tick landing on a transition is absorbed by the restart.
    if (state_n != state) cnt_n = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      cfg          <= '0;
      armed        <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      dout         <= '0;
      dout_we      <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      sh           <= sh_n;
      cfg          <= cfg_n;
      armed        <= armed_n;
      perr         <= perr_n;
      ferr         <= ferr_n;
      dout         <= dout_n;
      dout_we      <= we_n;
      frame_error  <= fe_n;
      parity_error <= pe_n;
      overrun      <= ov_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer.
// Driver pushes expected characters; monitor checks strobes.
module tb_uart_rx_deserializer;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_tick = 1'b0;
  logic       enable = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] data_bits_count = 2'b11;
  logic [1:0] parity_type = 2'b00;
  logic       double_stop_bits = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] dout;
  logic       dout_we;
  logic       frame_error;
  logic       parity_error;
  logic       overrun;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    bit         fe;
    bit         pe;
    bit         ov;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   strobes = 0;
  int   tcnt = 0;

  uart_rx_deserializer #(
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sample_tick     (sample_tick),
    .enable          (enable),
    .rx              (rx),
    .data_bits_count (data_bits_count),
    .parity_type     (parity_type),
    .double_stop_bits(double_stop_bits),
    .fifo_full       (fifo_full),
    .dout            (dout),
    .dout_we         (dout_we),
    .frame_error     (frame_error),
    .parity_error    (parity_error),
    .overrun         (overrun),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcnt        <= (tcnt + 1) % 4;
    sample_tick <= (tcnt == 3);
  end

  task automatic chk(input string n, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && (dout_we || overrun || frame_error || parity_error)) begin
      strobes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: we=%b ov=%b fe=%b pe=%b dout=%h",
                 dout_we, overrun, frame_error, parity_error, dout);
      end else begin
        e = exp_q.pop_front();
        chk("dout_we", 8'(dout_we), 8'(!e.ov));
        chk("overrun", 8'(overrun), 8'(e.ov));
        chk("frame_error", 8'(frame_error), 8'(e.fe));
        chk("parity_error", 8'(parity_error), 8'(e.pe));
        if (!e.ov) chk("dout", dout, e.d);
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb,
                            input logic [1:0] par, input bit dbl,
                            input bit flip, input bit s1low,
                            input bit s2low, input bit full);
    logic [7:0] v;
    logic [7:0] mask;
    bit   has_par;
    bit   pbit;
    exp_t e;
    mask    = 8'((1 << nb) - 1);
    v       = d & mask;
    has_par = (par == 2'b01) || (par == 2'b10);
    pbit    = (($countones(v) % 2) == 1) ^ (par == 2'b01) ^ flip;
    data_bits_count  = 2'(nb - 5);
    parity_type      = par;
    double_stop_bits = dbl;
    fifo_full        = full;
    e.d  = v;
    e.fe = s1low || (dbl && s2low);
    e.pe = has_par && flip;
    e.ov = full;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(v[i]);
    if (has_par) drive_bit(pbit);
    drive_bit(!s1low);
    if (dbl) drive_bit(!s2low);
  endtask

  task automatic frame(input logic [7:0] d, input int nb,
                       input logic [1:0] par, input bit dbl,
                       input bit flip, input bit s1low,
                       input bit s2low, input bit full);
    send_frame(d, nb, par, dbl, flip, s1low, s2low, full);
    idle(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    repeat (5) @(negedge clk);
    chk("rst_dout", dout, 8'h00);
    chk("rst_we", 8'(dout_we), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_fe", 8'(frame_error), 8'h00);
    chk("rst_pe", 8'(parity_error), 8'h00);
    chk("rst_ov", 8'(overrun), 8'h00);
    reset = 1'b1;
    idle(2);

    frame(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("busy_after_a5", 8'(busy), 8'h00);
    frame(8'h35, 7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'h35, 7, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    send_frame(8'h1F, 5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    s0 = strobes;
    rx = 1'b0;
    repeat (40 * BIT_CLKS) @(negedge clk);
    chk("break_strobes", 8'(strobes - s0), 8'h00);
    chk("break_busy", 8'(busy), 8'h00);
    idle(2);
    frame(8'h0A, 5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    s0 = strobes;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_busy_hi", 8'(busy), 8'h01);
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    chk("glitch_busy_lo", 8'(busy), 8'h00);
    idle(1);
    chk("glitch_strobes", 8'(strobes - s0), 8'h00);

    s0 = strobes;
    data_bits_count = 2'b11;
    parity_type = 2'b00;
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", 8'(busy), 8'h00);
    enable = 1'b1;
    idle(2);
    chk("abort_strobes", 8'(strobes - s0), 8'h00);

    frame(8'h42, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(8'h43, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("pre_reset_busy", 8'(busy), 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("async_dout", dout, 8'h00);
    chk("async_busy", 8'(busy), 8'h00);
    chk("async_we", 8'(dout_we), 8'h00);
    @(negedge clk);
    rx = 1'b1;
    reset = 1'b1;
    idle(2);
    frame(8'h80, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      frame(8'($urandom), 5 + int'($urandom_range(3)),
            2'($urandom_range(3)), bit'($urandom_range(1)),
            ($urandom_range(3) == 0), ($urandom_range(5) == 0),
            ($urandom_range(5) == 0), ($urandom_range(4) == 0));
    end

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++)
      @(negedge clk);
    chk("drain", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
